// File: rtl/obi_mem_responder_pkg.sv
// Shared types and constants for the req/gnt/rvalid memory responder.
package obi_mem_responder_pkg;

  localparam int unsigned RISCV_WORD_WIDTH = 32;
  localparam int unsigned BE_WIDTH         = 4;
  localparam int unsigned CNT_WIDTH        = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_DLY  = 2'd1,
    RESP_DLY = 2'd2,
    RESP     = 2'd3
  } resp_state_e;

endpackage

// File: rtl/obi_mem_responder_sram_bank.sv
// Single-port word array, 4-lane byte-enable write, registered read (1 cycle).
// No backpressure: every enabled cycle performs the access.
module sram_bank #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WIDTH       = 32,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH_WORDS];

  // Read returns the pre-write word; writes never need their own read data.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int k = 0; k < 4; k++) begin
          if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/obi_mem_responder.sv
// Memory responder: grant after GNT_WAIT held-req cycles, rvalid 1+RVALID_WAIT cycles after grant.
// stall_i or an outstanding response holds gnt_o low; one transaction in flight at most.
module obi_mem_responder
  import obi_mem_responder_pkg::*;
#(
  parameter int unsigned          WORD_WIDTH  = RISCV_WORD_WIDTH,
  parameter int unsigned          DEPTH_WORDS = 1024,
  parameter logic [WORD_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned          GNT_WAIT    = 0,
  parameter int unsigned          RVALID_WAIT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic [WORD_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  input  logic                  stall_i,
  output logic                  gnt_o,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_WIDTH-1:0] GNT_WAIT_C    = CNT_WIDTH'(GNT_WAIT);
  localparam logic [CNT_WIDTH-1:0] RVALID_WAIT_C = CNT_WIDTH'(RVALID_WAIT);
  localparam logic [WORD_WIDTH:0]  SPAN          = (WORD_WIDTH+1)'(DEPTH_WORDS) << 2;

  resp_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   we_q, err_q;
  logic                   gnt_ok, hs, in_range;
  logic [WORD_WIDTH:0]    offset;
  logic [AW-1:0]          idx;
  logic [WORD_WIDTH-1:0]  bank_rdata;

  // Extra top bit catches addresses below BASE_ADDR as a borrow.
  assign offset   = {1'b0, addr_i} - {1'b0, BASE_ADDR};
  assign in_range = ~offset[WORD_WIDTH] && (offset < SPAN);
  assign idx      = AW'(offset >> 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_ok  = 1'b0;
    case (state_q)
      IDLE, RESP: gnt_ok = (GNT_WAIT_C == '0);
      GNT_DLY:    gnt_ok = (cnt_q == GNT_WAIT_C);
      default:    gnt_ok = 1'b0;
    endcase
    gnt_o = rst_n & req_i & ~stall_i & gnt_ok;
    hs    = req_i & gnt_o;

    case (state_q)
      IDLE, RESP: begin
        if (req_i && (GNT_WAIT_C != '0)) begin
          state_d = GNT_DLY;
          cnt_d   = CNT_WIDTH'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      GNT_DLY: begin
        if (!req_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != GNT_WAIT_C) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      RESP_DLY: begin
        if (cnt_q <= CNT_WIDTH'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (hs) begin
      if (RVALID_WAIT_C != '0) begin
        state_d = RESP_DLY;
        cnt_d   = RVALID_WAIT_C;
      end else begin
        state_d = RESP;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hs) begin
        we_q  <= we_i;
        err_q <= ~in_range;
      end
    end
  end

  // Out-of-range accesses never touch the array.
  sram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .WIDTH       (WORD_WIDTH)
  ) u_bank (
    .clk   (clk),
    .en    (hs & in_range),
    .we    (we_i),
    .be    (be_i),
    .addr  (idx),
    .wdata (wdata_i),
    .rdata (bank_rdata)
  );

  assign rvalid_o = (state_q == RESP);
  assign err_o    = rvalid_o & err_q;
  assign rdata_o  = (rvalid_o && !we_q && !err_q) ? bank_rdata : '0;

endmodule

// File: doc/obi_mem_responder.md
Name: obi_mem_responder

Overview:
Memory-side responder for the core's req/gnt/rvalid memory interface. It serves either the instruction port or the data port from an internal byte-enabled word array. Grant delay and response latency are configurable, and a stall input injects backpressure. It is used as the instruction/data memory in the MiniSoc top and in core-level benches.

Parameters:
WORD_WIDTH, 32, data/address width; taken from riscv_defines.
DEPTH_WORDS, 1024, number of 32-bit words; must be a power of 2.
BASE_ADDR, 32'h0000_0000, byte address of word 0; word-aligned.
GNT_WAIT, 0, cycles req_i must be held before gnt_o can assert (0..15).
RVALID_WAIT, 0, extra cycles between the grant edge and rvalid_o (0..15).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset: synchronous, active-low.
req_i  in  1  request; the initiator holds it until a cycle where gnt_o=1.
addr_i  in  WORD_WIDTH  byte address; bits [1:0] are ignored.
we_i  in  1  1 = write, 0 = read.
be_i  in  4  byte enables; lane k covers bits [8k+7:8k].
wdata_i  in  WORD_WIDTH  write data.
stall_i  in  1  backpressure; forces gnt_o=0 while high.
gnt_o  out  1  request accepted this cycle; combinational.
rdata_o  out  WORD_WIDTH  read data; meaningful only while rvalid_o=1.
rvalid_o  out  1  one-cycle response pulse, one per grant.
err_o  out  1  address out of range; qualified by rvalid_o.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, counters=0, rvalid_o=0, rdata_o=0, err_o=0. gnt_o=0 while rst_n=0. Any pending response is dropped and no rvalid_o follows reset. The array is not cleared.
- States:
  - IDLE: no request pending.
  - GNT_DLY: counting held req_i cycles.
  - RESP_DLY: counting RVALID_WAIT.
  - RESP: rvalid_o=1.
- Grant condition: gnt_o = rst_n & req_i & ~stall_i & gnt_ok.
  - gnt_ok=1 in IDLE or RESP when GNT_WAIT=0.
  - gnt_ok=1 in GNT_DLY when the hold count has reached GNT_WAIT.
- IDLE/RESP with req_i=1, GNT_WAIT>0: go to GNT_DLY, hold count=1.
- GNT_DLY:
  - Count increments each cycle req_i=1 and saturates at GNT_WAIT.
  - req_i=0: return to IDLE, count cleared (protocol violation, tolerated).
  - stall_i=1 does not reset the count.
- Handshake edge (req_i & gnt_o):
  - Capture we_i, be_i, addr_i.
  - Writes commit to the array at this edge.
  - The read word is sampled at this edge.
  - Next state: RESP_DLY (loaded with RVALID_WAIT) if RVALID_WAIT>0, else RESP.
- RESP_DLY: decrement each cycle; enter RESP when the count reaches 0. gnt_o=0 in RESP_DLY, so at most one transaction is outstanding.
- RESP: rvalid_o=1 for exactly one cycle.
  - Read: rdata_o = sampled word.
  - Write: rdata_o = 0.
  - err_o = range error.
  - A new grant is allowed in the same cycle, so throughput is 1 transaction/cycle when both waits are 0.
  - No new grant: next state IDLE, or GNT_DLY if req_i=1 and GNT_WAIT>0.
- Latency: rvalid_o asserts 1+RVALID_WAIT cycles after the grant edge.
- rdata_o and err_o are registered; both are 0 whenever rvalid_o=0.
- Addressing: in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS (compare in WORD_WIDTH+1 bits so the upper bound does not overflow). Word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
- Out of range: no array write; response has rdata_o=0, err_o=1.
- Byte enables:
  - A write updates only lanes with be_i[k]=1.
  - be_i=0 on a write leaves the array unchanged and still produces a response.
  - Reads return the full word regardless of be_i.
- Hazard: a read granted the cycle after a write to the same word returns the new data (the write committed at the earlier edge).

Decomposition:
- ctrl_typedefs gains typedef enum logic [1:0] resp_state_e {IDLE, GNT_DLY, RESP_DLY, RESP}.
- WORD_WIDTH comes from riscv_defines.
- Sub-module sram_bank: a single-port synchronous array with 4-lane byte-enable write and registered read, parameter DEPTH_WORDS.
- obi_mem_responder holds the FSM, the counters, the range check and the output registers.

Test Plan:
1. GNT_WAIT=0, RVALID_WAIT=0: write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 on the next cycle. Expect gnt_o in the same cycle as req_i; rvalid_o 1 cycle after each grant; second response rdata_o=0xDEADBEEF, err_o=0.
2. Byte enables: preload 0x11223344 at 0x20, write 0xAABBCCDD with be=4'b0101, read back. Expect 0x11BB33DD.
3. GNT_WAIT=3, RVALID_WAIT=2, req_i held. Expect gnt_o on the 4th req_i cycle and rvalid_o exactly 3 cycles after the grant edge. If req_i drops after 2 cycles, expect no gnt_o and state IDLE.
4. stall_i=1 for 5 cycles with req_i held. Expect gnt_o=0 throughout and a grant in the first cycle after stall_i falls.
5. Out of range: read BASE_ADDR+4*DEPTH_WORDS and write 0xFFFF_FFFC with BASE_ADDR=0, DEPTH_WORDS=1024. Expect rvalid_o=1, err_o=1, rdata_o=0, and the array unchanged.
6. Back-to-back and reset: 8 consecutive reads with waits=0 give 8 rvalid_o pulses in 8 consecutive cycles. Asserting rst_n=0 in RESP_DLY gives rvalid_o=0 afterwards, and a subsequent read returns pre-reset array contents.
